writeback_stage: RTL and testbench

- Final pipeline stage of the CPU; sole initiator of the register bank write port (write_enable / write_address / write_value).
- Accepts ALU results and load requests from execute.
- For loads, waits for memory read data, then byte/halfword-extracts and sign/zero-extends it.
- Exports the pending-load destination so decode can stall on load-use hazards.

---
 rtl/writeback_stage.sv | 100 ++++++++++
 tb/tb_writeback_stage.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/writeback_stage.sv
// writeback_stage: final pipeline stage that drives the register bank write port and waits on load data (optional WB_RETIRE_COUNT_EN adds retired_count)
module writeback_stage #(
  parameter int TIMEOUT = 255,
  parameter int CNT_W = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ex_valid,
  output logic        ex_ready,
  input  logic [4:0]  ex_rd,
  input  logic [31:0] ex_result,
  input  logic        ex_is_load,
  input  logic [2:0]  ex_funct3,
  input  logic [1:0]  ex_addr_lo,
  input  logic        mem_data_valid,
  input  logic [31:0] mem_rdata,
  output logic        write_enable,
  output logic [4:0]  write_address,
  output logic [31:0] write_value,
  output logic        load_pending,
  output logic [4:0]  load_pending_rd,
`ifdef WB_RETIRE_COUNT_EN
  output logic [31:0] retired_count,
`endif
  output logic        mem_error
);
  typedef enum logic {IDLE, WAIT_MEM} state_t;
  state_t state, state_n;
  logic [CNT_W-1:0] cnt;
  logic [4:0] rd_q;
  logic [2:0] f3_q;
  logic [1:0] lo_q;
  logic [7:0] b;
  logic [15:0] h;
  logic [31:0] ext;
  logic timed_out, we_n;
  assign ex_ready = state == IDLE;
  always_comb begin
    b = mem_rdata[{lo_q, 3'b000} +: 8];
    h = mem_rdata[{lo_q[1], 4'b0000} +: 16];
    ext = f3_q == 3'b000 ? {{24{b[7]}}, b} :
          f3_q == 3'b001 ? {{16{h[15]}}, h} :
          f3_q == 3'b100 ? {24'b0, b} :
          f3_q == 3'b101 ? {16'b0, h} : mem_rdata;
    timed_out = TIMEOUT != 0 && cnt == CNT_W'(TIMEOUT) && !mem_data_valid;
    we_n = state == IDLE ? ex_valid && !ex_is_load && ex_rd != 5'd0
                         : mem_data_valid && rd_q != 5'd0;
    state_n = state == IDLE ? (ex_valid && ex_is_load ? WAIT_MEM : IDLE)
                            : (mem_data_valid || timed_out ? IDLE : WAIT_MEM);
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
      cnt <= '0;
      rd_q <= '0;
      f3_q <= '0;
      lo_q <= '0;
      write_enable <= 1'b0;
      write_address <= '0;
      write_value <= '0;
      load_pending <= 1'b0;
      load_pending_rd <= '0;
      mem_error <= 1'b0;
    end else begin
      state <= state_n;
      write_enable <= we_n;
      mem_error <= 1'b0;
      if (state == IDLE) begin
        if (ex_valid && ex_is_load) begin
          rd_q <= ex_rd;
          f3_q <= ex_funct3;
          lo_q <= ex_addr_lo;
          cnt <= '0;
          load_pending <= 1'b1;
          load_pending_rd <= ex_rd;
        end else if (ex_valid) begin
          write_address <= ex_rd;
          write_value <= ex_result;
        end
      end else if (mem_data_valid) begin
        write_address <= rd_q;
        write_value <= ext;
        load_pending <= 1'b0;
        load_pending_rd <= '0;
      end else if (timed_out) begin
        mem_error <= 1'b1;
        load_pending <= 1'b0;
        load_pending_rd <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end
`ifdef WB_RETIRE_COUNT_EN
  always_ff @(posedge clk) begin
    if (!reset) retired_count <= '0;
    else if (we_n) retired_count <= retired_count + 32'd1;
  end
`endif
endmodule

// File: tb/tb_writeback_stage.sv
// tb_writeback_stage: directed test-plan cases plus randomized traffic checked every cycle against a behavioural model
module tb_writeback_stage;
  localparam int TO = 4;
  logic clk = 1'b0, reset = 1'b0;
  logic ex_valid = 1'b0, ex_ready, ex_is_load = 1'b0;
  logic [4:0] ex_rd = '0;
  logic [31:0] ex_result = '0;
  logic [2:0] ex_funct3 = '0;
  logic [1:0] ex_addr_lo = '0;
  logic mem_data_valid = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic write_enable, load_pending, mem_error;
  logic [4:0] write_address, load_pending_rd;
  logic [31:0] write_value;
`ifdef WB_RETIRE_COUNT_EN
  logic [31:0] retired_count;
`endif
  int n_chk = 0, n_fail = 0;
  bit started = 1'b0;
  writeback_stage #(.TIMEOUT(TO), .CNT_W(8)) dut (
    .clk(clk), .reset(reset), .ex_valid(ex_valid), .ex_ready(ex_ready),
    .ex_rd(ex_rd), .ex_result(ex_result), .ex_is_load(ex_is_load),
    .ex_funct3(ex_funct3), .ex_addr_lo(ex_addr_lo),
    .mem_data_valid(mem_data_valid), .mem_rdata(mem_rdata),
    .write_enable(write_enable), .write_address(write_address),
    .write_value(write_value), .load_pending(load_pending),
    .load_pending_rd(load_pending_rd),
`ifdef WB_RETIRE_COUNT_EN
    .retired_count(retired_count),
`endif
    .mem_error(mem_error)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask
  function automatic logic [31:0] extract(input logic [2:0] f, input logic [1:0] lo, input logic [31:0] w);
    int b, h;
    b = int'((w >> (8 * int'(lo))) & 32'hFF);
    h = int'((w >> (16 * int'(lo[1]))) & 32'hFFFF);
    case (f)
      3'b000: return 32'(b >= 128 ? b - 256 : b);
      3'b001: return 32'(h >= 32768 ? h - 65536 : h);
      3'b100: return 32'(b);
      3'b101: return 32'(h);
      default: return w;
    endcase
  endfunction
  bit m_wait, m_we, m_lp, m_err;
  int m_waited;
  logic [4:0] m_rd, m_wa, m_lprd;
  logic [2:0] m_f3;
  logic [1:0] m_lo;
  logic [31:0] m_wv, m_rc;
  always @(posedge clk) begin
    if (!reset) begin
      m_wait = 0; m_we = 0; m_lp = 0; m_err = 0; m_waited = 0;
      m_wa = 0; m_wv = 0; m_lprd = 0; m_rc = 0;
    end else begin
      m_we = 0; m_err = 0;
      if (!m_wait) begin
        if (ex_valid && ex_is_load) begin
          m_wait = 1; m_waited = 0; m_rd = ex_rd; m_f3 = ex_funct3; m_lo = ex_addr_lo;
          m_lp = 1; m_lprd = ex_rd;
        end else if (ex_valid) begin
          m_we = ex_rd != 0; m_wa = ex_rd; m_wv = ex_result;
        end
      end else if (mem_data_valid) begin
        m_we = m_rd != 0; m_wa = m_rd; m_wv = extract(m_f3, m_lo, mem_rdata);
        m_wait = 0; m_lp = 0; m_lprd = 0;
      end else if (m_waited == TO) begin
        m_err = 1; m_wait = 0; m_lp = 0; m_lprd = 0;
      end else m_waited++;
      if (m_we) m_rc = m_rc + 1;
    end
  end
  always @(negedge clk) if (started) begin
    chk("m_ex_ready", 32'(ex_ready), 32'(!m_wait));
    chk("m_write_enable", 32'(write_enable), 32'(m_we));
    chk("m_write_address", 32'(write_address), 32'(m_wa));
    chk("m_write_value", write_value, m_wv);
    chk("m_load_pending", 32'(load_pending), 32'(m_lp));
    chk("m_load_pending_rd", 32'(load_pending_rd), 32'(m_lprd));
    chk("m_mem_error", 32'(mem_error), 32'(m_err));
`ifdef WB_RETIRE_COUNT_EN
    chk("m_retired_count", retired_count, m_rc);
`endif
  end
  task automatic step();
    @(posedge clk); #1;
  endtask
  task automatic issue_load(input logic [4:0] rd, input logic [2:0] f, input logic [1:0] lo);
    ex_valid = 1; ex_is_load = 1; ex_rd = rd; ex_funct3 = f; ex_addr_lo = lo;
    step();
    ex_valid = 0; ex_is_load = 0;
  endtask
  task automatic feed(input logic [31:0] d);
    mem_data_valid = 1; mem_rdata = d;
    step();
    mem_data_valid = 0;
  endtask
  initial begin
    reset = 0;
    step(); started = 1; step();
    chk("reset_we", 32'(write_enable), 0);
    chk("reset_ready", 32'(ex_ready), 1);
    reset = 1;
    ex_valid = 1; ex_rd = 5; ex_result = 32'h12345678; step();
    chk("b2b_first", {write_enable, 10'd0, write_address, 16'd0}, {1'b1, 10'd0, 5'd5, 16'd0});
    chk("b2b_first_val", write_value, 32'h12345678);
    ex_rd = 6; ex_result = 32'hCAFEBABE; step();
    chk("b2b_second", {write_enable, 10'd0, write_address, 16'd0}, {1'b1, 10'd0, 5'd6, 16'd0});
    chk("b2b_second_val", write_value, 32'hCAFEBABE);
    chk("b2b_ready", 32'(ex_ready), 1);
    ex_valid = 0;
    issue_load(7, 3'b000, 2'd3);
    repeat (4) begin
      chk("lb_pending", {27'd0, load_pending_rd} | (32'(load_pending) << 8), 32'h107);
      chk("lb_ready_low", 32'(ex_ready), 0);
      step();
    end
    feed(32'h80FF0102);
    chk("lb_value", write_value, 32'hFFFFFF80);
    chk("lb_we_addr", {31'd0, write_enable} | 32'(write_address) << 8, 32'h701);
`ifdef WB_RETIRE_COUNT_EN
    chk("retired_3", retired_count, 3);
`endif
    issue_load(8, 3'b101, 2'd2); feed(32'h9ABC0000);
    chk("lhu_value", write_value, 32'h00009ABC);
    issue_load(9, 3'b001, 2'd2); feed(32'h9ABC0000);
    chk("lh_value", write_value, 32'hFFFF9ABC);
    issue_load(10, 3'b100, 2'd1); feed(32'h0000AB00);
    chk("lbu_value", write_value, 32'h000000AB);
    ex_valid = 1; ex_rd = 0; ex_result = 32'hFFFFFFFF; step(); ex_valid = 0;
    chk("rd0_alu_no_we", 32'(write_enable), 0);
    issue_load(0, 3'b010, 2'd0);
    chk("rd0_load_pending", {31'd0, load_pending} | 32'(load_pending_rd) << 8, 1);
    step(); feed(32'h11111111);
    chk("rd0_load_no_we", 32'(write_enable), 0);
    chk("rd0_load_done", 32'(load_pending), 0);
    issue_load(11, 3'b010, 2'd0);
    repeat (TO) begin chk("to_no_err_yet", 32'(mem_error), 0); step(); end
    step();
    chk("to_err", 32'(mem_error), 1);
    chk("to_no_we", 32'(write_enable), 0);
    chk("to_ready", 32'(ex_ready), 1);
    chk("to_pending", 32'(load_pending), 0);
    step();
    chk("to_err_pulse", 32'(mem_error), 0);
    issue_load(12, 3'b010, 2'd0); step();
    reset = 0; step(); reset = 1;
    feed(32'h55555555);
    chk("rst_mid_we", 32'(write_enable), 0);
    chk("rst_mid_pending", 32'(load_pending), 0);
    chk("rst_mid_val", write_value, 0);
`ifdef WB_RETIRE_COUNT_EN
    chk("rst_mid_count", retired_count, 0);
`endif
    repeat (3000) begin
      reset = $urandom_range(199) != 0;
      ex_valid = $urandom_range(1) == 1;
      ex_is_load = $urandom_range(2) == 0;
      ex_rd = $urandom_range(9) == 0 ? 5'd0 : 5'($urandom_range(31));
      ex_result = $urandom;
      ex_funct3 = 3'($urandom_range(7));
      ex_addr_lo = 2'($urandom_range(3));
      mem_data_valid = $urandom_range(3) == 0;
      mem_rdata = $urandom;
      step();
    end
    reset = 1; ex_valid = 0; mem_data_valid = 0;
    step(); step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
